// File: rtl/pipeline_skid_reg.sv
// Two-entry pipeline skid register with a registered ready/valid handshake.
// The main register drives out_data; the skid register catches the one word
// that arrives on the edge where downstream stalls while the main register is
// occupied. in_ready, out_valid, out_data and occupancy all come straight
// from flops, so no input reaches any output combinationally.
module pipeline_skid_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] main_reg;
    logic [WIDTH-1:0] skid_reg;
    logic             in_ready_reg;
    logic             out_valid_reg;
    logic [1:0]       occupancy_reg;

    logic in_fire;
    logic out_fire;

    // Handshake qualifiers use only the registered ready/valid, so a transfer
    // never depends on a value that was computed from the same cycle's inputs.
    assign in_fire  = in_valid & in_ready_reg;
    assign out_fire = out_valid_reg & out_ready;

    // Single state machine: state, payload registers and all registered outputs
    // are updated together from the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= EMPTY;
            main_reg      <= '0;
            skid_reg      <= '0;
            in_ready_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            occupancy_reg <= 2'd0;
        end else begin
            case (state_reg)
                EMPTY: begin
                    // in_ready is low only on the first edge after reset;
                    // raising it here opens the input from the next cycle.
                    in_ready_reg <= 1'b1;
                    if (in_fire) begin
                        main_reg      <= in_data;
                        state_reg     <= BUSY;
                        out_valid_reg <= 1'b1;
                        occupancy_reg <= 2'd1;
                    end
                end
                BUSY: begin
                    if (in_fire && !out_fire) begin
                        // Downstream stalled: park the new word behind main.
                        skid_reg      <= in_data;
                        state_reg     <= FULL;
                        in_ready_reg  <= 1'b0;
                        occupancy_reg <= 2'd2;
                    end else if (in_fire && out_fire) begin
                        // Pass-through: old word leaves, new word replaces it.
                        main_reg <= in_data;
                    end else if (out_fire) begin
                        state_reg     <= EMPTY;
                        out_valid_reg <= 1'b0;
                        occupancy_reg <= 2'd0;
                    end
                end
                FULL: begin
                    // No input can arrive here because in_ready is low.
                    if (out_fire) begin
                        main_reg      <= skid_reg;
                        state_reg     <= BUSY;
                        in_ready_reg  <= 1'b1;
                        occupancy_reg <= 2'd1;
                    end
                end
                default: begin
                    state_reg     <= EMPTY;
                    in_ready_reg  <= 1'b0;
                    out_valid_reg <= 1'b0;
                    occupancy_reg <= 2'd0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_data  = main_reg;
    assign occupancy = occupancy_reg;

endmodule

// File: tb/tb_pipeline_skid_reg.sv
// Self-checking bench for pipeline_skid_reg. A queue-based reference model
// (a FIFO of capacity two plus a post-reset ready flag) predicts every
// registered output; each scenario task performs its own comparisons.
module tb_pipeline_skid_reg;

    localparam int WIDTH = 32;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       occupancy;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [WIDTH-1:0] model_q[$];
    logic             model_ready;
    logic             last_in_fire;
    logic             last_out_fire;

    pipeline_skid_reg #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock edge and update the model from the inputs in force
    // at that edge; returns at the following falling edge for sampling.
    task automatic step();
        logic fin;
        logic fout;
        fin  = 1'b0;
        fout = 1'b0;
        @(posedge clk);
        if (reset) begin
            model_q.delete();
            model_ready = 1'b0;
        end else begin
            fin  = in_valid && model_ready;
            fout = (model_q.size() > 0) && out_ready;
            if (fout) void'(model_q.pop_front());
            if (fin) model_q.push_back(in_data);
            model_ready = (model_q.size() < 2);
        end
        last_in_fire  = fin;
        last_out_fire = fout;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h5555_AAAA;
        out_ready = 1'b1;
        step();
        step();
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_in_ready got=%0b want=0", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_out_valid got=%0b want=0", out_valid);
        end
        checks++;
        if (occupancy !== 2'd0) begin
            failures++;
            $display("FAIL reset_occupancy got=%0d want=0", occupancy);
        end
        checks++;
        if (out_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_out_data got=%h want=00000000", out_data);
        end
        // First edge out of reset: in_ready is still low so the offer is dropped.
        reset    = 1'b0;
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        step();
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_in_ready got=%0b want=1", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            failures++;
            $display("FAIL post_reset_no_accept got_valid=%0b got_occ=%0d want_valid=0 want_occ=0",
                     out_valid, occupancy);
        end
        in_valid = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_single();
        in_valid  = 1'b1;
        in_data   = 32'hA5A5_A5A5;
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'hA5A5_A5A5 || occupancy !== 2'd1) begin
            failures++;
            $display("FAIL single_latency got_valid=%0b got_data=%h got_occ=%0d want 1 a5a5a5a5 1",
                     out_valid, out_data, occupancy);
        end
        $display("xfer out data=%h", out_data);
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            failures++;
            $display("FAIL single_drain got_valid=%0b got_occ=%0d want 0 0", out_valid, occupancy);
        end
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = WIDTH'(i);
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("FAIL stream_in_ready word=%0d got=%0b want=1", i, in_ready);
            end
            step();
            checks++;
            if (out_valid !== 1'b1 || out_data !== WIDTH'(i)) begin
                failures++;
                $display("FAIL stream_data word=%0d got_valid=%0b got_data=%h want_data=%h",
                         i, out_valid, out_data, WIDTH'(i));
            end
            $display("xfer out data=%h", out_data);
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (occupancy !== 2'd0) begin
            failures++;
            $display("FAIL stream_drain got_occ=%0d want=0", occupancy);
        end
    endtask

    task automatic test_stall();
        logic [WIDTH-1:0] vals[3];
        logic [WIDTH-1:0] outs[$];
        int idx;
        vals[0] = 32'h11;
        vals[1] = 32'h22;
        vals[2] = 32'h33;
        idx = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1;
            in_data  = vals[idx];
            step();
            if (last_in_fire) idx++;
        end
        checks++;
        if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 32'h11) begin
            failures++;
            $display("FAIL stall_full got_occ=%0d got_ready=%0b got_data=%h want 2 0 00000011",
                     occupancy, in_ready, out_data);
        end
        checks++;
        if (idx !== 2) begin
            failures++;
            $display("FAIL stall_accepted got=%0d want=2", idx);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 8 && outs.size() < 3; c++) begin
            if (out_valid && out_ready) begin
                outs.push_back(out_data);
                $display("xfer out data=%h", out_data);
            end
            if (outs.size() < 3) begin
                in_valid = (idx < 3);
                in_data  = vals[(idx < 3) ? idx : 0];
                step();
                if (last_in_fire) idx++;
            end
        end
        checks++;
        if (outs.size() != 3) begin
            failures++;
            $display("FAIL stall_count got=%0d want=3", outs.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (outs[k] !== vals[k]) begin
                    failures++;
                    $display("FAIL stall_order idx=%0d got=%h want=%h", k, outs[k], vals[k]);
                end
            end
        end
        in_valid = 1'b0;
        step();
        step();
    endtask

    task automatic test_back_to_back();
        in_valid  = 1'b1;
        in_data   = 32'h1234_5678;
        out_ready = 1'b0;
        step();
        checks++;
        if (occupancy !== 2'd1 || out_data !== 32'h1234_5678) begin
            failures++;
            $display("FAIL b2b_busy got_occ=%0d got_data=%h want 1 12345678", occupancy, out_data);
        end
        in_data   = 32'hCAFE_F00D;
        out_ready = 1'b1;
        step();
        checks++;
        if (occupancy !== 2'd1 || out_data !== 32'hCAFE_F00D || out_valid !== 1'b1 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_pass got_occ=%0d got_data=%h got_valid=%0b got_ready=%0b want 1 cafef00d 1 1",
                     occupancy, out_data, out_valid, in_ready);
        end
        $display("xfer out data=%h", out_data);
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_reset_full();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hAAAA_0001;
        step();
        in_data   = 32'hAAAA_0002;
        step();
        checks++;
        if (occupancy !== 2'd2) begin
            failures++;
            $display("FAIL rfull_fill got_occ=%0d want=2", occupancy);
        end
        reset     = 1'b1;
        out_ready = 1'b1;
        in_data   = 32'hAAAA_0003;
        step();
        checks++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b0 || out_data !== 32'h0) begin
            failures++;
            $display("FAIL rfull_cleared got_valid=%0b got_occ=%0d got_ready=%0b got_data=%h want 0 0 0 0",
                     out_valid, occupancy, in_ready, out_data);
        end
        reset    = 1'b0;
        in_valid = 1'b0;
        step();
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rfull_ready got=%0b want=1", in_ready);
        end
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL rfull_ghost cycle=%0d got_valid=%0b got_data=%h want_valid=0",
                         c, out_valid, out_data);
            end
            step();
        end
    endtask

    task automatic test_random();
        logic             prev_valid;
        logic             prev_ready;
        logic [WIDTH-1:0] prev_data;
        int               n_out;
        n_out = 0;
        for (int c = 0; c < 10000; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = $urandom;
            out_ready = 1'($urandom_range(0, 1));
            prev_valid = out_valid;
            prev_ready = out_ready;
            prev_data  = out_data;
            step();
            if (last_out_fire) n_out++;
            if (prev_valid && !prev_ready) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== prev_data) begin
                    failures++;
                    $display("FAIL rand_stable cycle=%0d got=%h want=%h", c, out_data, prev_data);
                end
            end
            checks++;
            if (in_ready !== model_ready) begin
                failures++;
                $display("FAIL rand_in_ready cycle=%0d got=%0b want=%0b", c, in_ready, model_ready);
            end
            checks++;
            if (occupancy !== 2'(model_q.size()) || occupancy > 2'd2) begin
                failures++;
                $display("FAIL rand_occupancy cycle=%0d got=%0d want=%0d", c, occupancy, model_q.size());
            end
            checks++;
            if (out_valid !== (model_q.size() > 0)) begin
                failures++;
                $display("FAIL rand_out_valid cycle=%0d got=%0b want=%0b", c, out_valid, model_q.size() > 0);
            end
            if (model_q.size() > 0) begin
                checks++;
                if (out_data !== model_q[0]) begin
                    failures++;
                    $display("FAIL rand_out_data cycle=%0d got=%h want=%h", c, out_data, model_q[0]);
                end
            end
        end
        $display("test_random done outputs=%0d", n_out);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        step();
    endtask

    initial begin
        reset         = 1'b1;
        in_valid      = 1'b0;
        in_data       = '0;
        out_ready     = 1'b0;
        model_ready   = 1'b0;
        last_in_fire  = 1'b0;
        last_out_fire = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_stream();
        test_stall();
        test_back_to_back();
        test_reset_full();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_skid_reg.md
PIPELINE_SKID_REG -- requirements
Module: pipeline_skid_reg

Interface
REQ-001 Parameter: WIDTH, default 32, payload width in bits.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 in_valid  input  1  upstream offers in_data this cycle.
REQ-005 in_ready  output  1  block accepts upstream data this cycle; driven directly from a flop.
REQ-006 in_data  input  WIDTH  upstream payload.
REQ-007 out_valid  output  1  out_data holds a valid word; driven directly from a flop.
REQ-008 out_ready  input  1  downstream accepts out_data this cycle.
REQ-009 out_data  output  WIDTH  downstream payload; driven directly from the main data flop.
REQ-010 occupancy  output  2  number of words held: 0, 1 or 2.

Function
REQ-011 An input transfer (in_fire) SHALL occur on a rising edge where in_valid=1 and in_ready=1; an output transfer (out_fire) SHALL occur where out_valid=1 and out_ready=1.
REQ-012 Storage SHALL be one main register (drives out_data) and one skid register; there SHALL be no combinational path from any input to in_ready, out_valid or out_data.
REQ-013 The state machine SHALL have the states EMPTY (0 words), BUSY (1 word, in main) and FULL (2 words, oldest in main, newest in skid).
REQ-014 EMPTY: on in_fire, main<=in_data and the state goes to BUSY; otherwise the state holds.
REQ-015 BUSY: in_fire and no out_fire -> skid<=in_data, go to FULL; in_fire and out_fire -> main<=in_data, stay BUSY; out_fire only -> go to EMPTY; neither -> hold.
REQ-016 FULL: on out_fire, main<=skid and the state goes to BUSY; in_fire cannot occur because in_ready=0.
REQ-017 Registered outputs: in_ready=1 in EMPTY and BUSY, 0 in FULL; out_valid=0 in EMPTY, 1 in BUSY and FULL; occupancy=0/1/2 for EMPTY/BUSY/FULL.
REQ-018 Latency from in_fire to out_valid=1 with that word on out_data SHALL be exactly one cycle when the block is EMPTY, or when it is BUSY and out_fire occurs on the same edge.
REQ-019 With out_ready held at 1, throughput SHALL be one word per cycle indefinitely, with no bubbles.
REQ-020 Words SHALL leave in acceptance order, with none lost or duplicated.
REQ-021 While out_valid=1 and out_ready=0, out_data SHALL remain stable.
REQ-022 When in_fire does not occur, in_data SHALL be ignored; no register is loaded from it.
REQ-023 out_ready asserted while out_valid=0 SHALL have no effect.

Reset
REQ-024 On a clock edge with reset=1, the block SHALL set state=EMPTY, out_valid=0, in_ready=0, occupancy=0, and clear main and skid to 0.
REQ-025 The first rising edge with reset=0 SHALL set in_ready=1, so the block accepts from the second post-reset cycle.
REQ-026 Reset asserted mid-operation, including in FULL, SHALL discard all held words on that edge, and no out_fire SHALL be reported afterwards.
REQ-027 Transfers offered while reset=1 SHALL be discarded.

Verification
REQ-028 Reset, then in_valid=1 with in_data=0xA5A5A5A5 while out_ready=1 -> one cycle later out_valid=1, out_data=0xA5A5A5A5, occupancy=1.
REQ-029 Stream 0x1..0x8 on consecutive cycles with out_ready=1 -> out_data shows 0x1..0x8 on 8 consecutive cycles, in_ready never drops.
REQ-030 Hold out_ready=0 and offer 0x11, 0x22, 0x33 -> 0x11 and 0x22 accepted, occupancy=2, in_ready=0, 0x33 held upstream; raise out_ready -> outputs 0x11, 0x22, 0x33 in order.
REQ-031 Random in_valid and out_ready at 50% each over 10000 cycles -> scoreboard matches in order, out_data stable during stalls, occupancy never exceeds 2.
REQ-032 In FULL, assert reset for one cycle -> next cycle out_valid=0 and occupancy=0; one cycle after that in_ready=1, and the old words never appear.
REQ-033 In BUSY, assert in_valid and out_ready on the same edge -> state stays BUSY, out_data equals the new word, occupancy=1.
